// File: rtl/fpu_pkg.sv
// fpu_pkg: shared types and constants for the FPU rounder datapath.
//   EMIN_DBL / EMIN_SGL : minimum normal exponents for double / single
//   SH_W / EO_W         : widths of the shift amount and result exponent
//   sh_t / eo_t         : signed 13-bit shift / 14-bit exponent types
//   s1_t                : norm_shift stage-1 register contents
//   sat_sh()            : clamp a 14-bit signed value into the sh_t range
package fpu_pkg;

  localparam int SH_W = 13;
  localparam int EO_W = 14;

  typedef logic signed [SH_W-1:0] sh_t;
  typedef logic signed [EO_W-1:0] eo_t;

  localparam sh_t EMIN_DBL = -13'sd1022;
  localparam sh_t EMIN_SGL = -13'sd126;

  localparam eo_t SH_MAX = 14'sd4095;
  localparam eo_t SH_MIN = -14'sd4096;

  // Chunk 0 of clz/zf covers fr[63:48], chunk 3 covers fr[15:0].
  typedef struct packed {
    logic [3:0][4:0] clz;
    logic [3:0]      zf;
    eo_t             d;
    sh_t             er;
  } s1_t;

  function automatic sh_t sat_sh(input eo_t v);
    if (v > SH_MAX) begin
      return sh_t'(SH_MAX);
    end else if (v < SH_MIN) begin
      return sh_t'(SH_MIN);
    end else begin
      return sh_t'(v);
    end
  endfunction

endpackage

// File: rtl/norm_shift_if.sv
// norm_shift_if: valid/ready operand and result bus of norm_shift.
//   in_valid/in_ready   : operand handshake
//   fr, er              : unnormalized significand and its exponent
//   out_valid/out_ready : result handshake
//   sh, eo, zero        : shift amount, result exponent, zero-operand flag
// The master modport is the side producing operands and consuming results;
// the slave modport is the norm_shift block itself.
interface norm_shift_if;
  import fpu_pkg::*;

  logic        in_valid;
  logic        in_ready;
  logic [63:0] fr;
  sh_t         er;
  logic        out_valid;
  logic        out_ready;
  sh_t         sh;
  eo_t         eo;
  logic        zero;

  modport master (
    output in_valid, fr, er, out_ready,
    input  in_ready, out_valid, sh, eo, zero
  );

  modport slave (
    input  in_valid, fr, er, out_ready,
    output in_ready, out_valid, sh, eo, zero
  );

endinterface

// File: rtl/norm_shift_lzc16.sv
// lzc16: combinational leading-zero counter for one 16-bit chunk.
//   x        : input chunk, MSB = bit 15
//   cnt      : number of leading zeros, 0..16 (16 only when x == 0)
//   all_zero : x is all zeros
module lzc16 (
  input  logic [15:0] x,
  output logic [4:0]  cnt,
  output logic        all_zero
);

  // Scanning upward lets the highest set bit overwrite any lower one.
  always_comb begin
    cnt = 5'd16;
    for (int i = 0; i < 16; i++) begin
      if (x[i]) begin
        cnt = 5'(15 - i);
      end
    end
  end

  assign all_zero = (x == 16'd0);

endmodule

// File: rtl/norm_shift.sv
// norm_shift: two-stage valid/ready normalization-shift generator.
// Computes sh = sat13(min(lz(fr), er - EMIN)) and eo = er - sh; a zero
// significand yields zero = 1, sh = 0, eo = er.
//   EMIN  : minimum normal exponent (EMIN_DBL or EMIN_SGL)
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, discards anything in flight
//   bus   : norm_shift_if slave (operand in, result out)
// Stage 1 registers per-chunk leading-zero counts plus d and er; stage 2
// merges the chunks, applies the exponent clamp and registers the result.
module norm_shift
  import fpu_pkg::*;
#(
  parameter sh_t EMIN = EMIN_DBL
) (
  input  logic         clk,
  input  logic         rst_n,
  norm_shift_if.slave  bus
);

  logic            s1_valid;
  logic            s2_valid;
  logic            s1_adv;
  logic            s2_adv;
  s1_t             s1_q;
  s1_t             s1_next;
  logic [3:0][4:0] chunk_clz;
  logic [3:0]      chunk_zf;
  logic [6:0]      lz;
  eo_t             lz_ext;
  eo_t             min_v;
  sh_t             sh_next;
  eo_t             eo_next;
  logic            zero_next;
  sh_t             sh_q;
  eo_t             eo_q;
  logic            zero_q;

  // A stage may take new data when it is empty or its contents are leaving.
  assign s2_adv       = !s2_valid || bus.out_ready;
  assign s1_adv       = !s1_valid || s2_adv;
  assign bus.in_ready = s1_adv;

  for (genvar g = 0; g < 4; g++) begin : g_lzc
    lzc16 u_lzc (
      .x        (bus.fr[63-16*g -: 16]),
      .cnt      (chunk_clz[g]),
      .all_zero (chunk_zf[g])
    );
  end

  always_comb begin
    s1_next     = '0;
    s1_next.clz = chunk_clz;
    s1_next.zf  = chunk_zf;
    s1_next.d   = eo_t'(bus.er) - eo_t'(EMIN);
    s1_next.er  = bus.er;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_q <= s1_next;
      end
    end
  end

  // Chunks are walked from least to most significant so the first non-zero
  // chunk from the top is the one left in lz.
  always_comb begin
    lz = 7'd64;
    for (int k = 3; k >= 0; k--) begin
      if (!s1_q.zf[k]) begin
        lz = 7'(16 * k) + 7'(s1_q.clz[k]);
      end
    end
  end

  // The shift stops early when the exponent would fall below EMIN; a
  // negative d turns the left shift into a denormalizing right shift.
  always_comb begin
    lz_ext    = eo_t'({7'd0, lz});
    min_v     = (lz_ext < s1_q.d) ? lz_ext : s1_q.d;
    sh_next   = sat_sh(min_v);
    eo_next   = eo_t'(s1_q.er) - eo_t'(sh_next);
    zero_next = 1'b0;
    if (&s1_q.zf) begin
      sh_next   = '0;
      eo_next   = eo_t'(s1_q.er);
      zero_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      sh_q     <= '0;
      eo_q     <= '0;
      zero_q   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        sh_q   <= sh_next;
        eo_q   <= eo_next;
        zero_q <= zero_next;
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.sh        = sh_q;
  assign bus.eo        = eo_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_norm_shift.sv
// tb_norm_shift: scoreboard bench for norm_shift with hand-computed vectors.
// The stimulus side pushes expected results on acceptance; a monitor pops
// and compares them whenever a result is consumed.
module tb_norm_shift;
  import fpu_pkg::*;

  typedef struct {
    logic [63:0] fr;
    int          er;
    int          sh;
    int          eo;
    bit          zero;
  } vec_t;

  typedef struct {
    sh_t  sh;
    eo_t  eo;
    logic zero;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  norm_shift_if bus ();

  norm_shift #(.EMIN(EMIN_DBL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   n_acc  = 0;
  int   n_emit = 0;

  bit   rdy_toggle = 1'b0;
  bit   rdy_force  = 1'b1;
  int   rdy_idx    = 0;
  bit   rdy_pat[8] = '{1, 0, 0, 0, 1, 1, 0, 1};

  // EMIN = -1022 throughout.
  vec_t dir_v[5] = '{
    '{64'h0000_0000_0000_0001,     0,  63,   -63, 1'b0},
    '{64'h8000_0000_0000_0000,     5,   0,     5, 1'b0},
    '{64'h0010_0000_0000_0000, -1020,   2, -1022, 1'b0},
    '{64'h8000_0000_0000_0000, -1030,  -8, -1022, 1'b0},
    '{64'h0000_0000_0000_0000,     7,   0,     7, 1'b1}
  };

  vec_t str_v[8] = '{
    '{64'h0000_FFFF_0000_0000,   100,    16,    84, 1'b0},
    '{64'h0000_0000_0001_0000,   -10,    47,   -57, 1'b0},
    '{64'h0000_0000_0000_8000, -1000,    22, -1022, 1'b0},
    '{64'h4000_0000_0000_0000, -4096, -3074, -1022, 1'b0},
    '{64'h0000_0000_0000_0000,    -5,     0,    -5, 1'b1},
    '{64'h0123_4567_89AB_CDEF,  4095,     7,  4088, 1'b0},
    '{64'h0000_0800_0000_0000, -1022,     0, -1022, 1'b0},
    '{64'h0000_0000_0000_0001, -1023,    -1, -1022, 1'b0}
  };

  task automatic checkOutput(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic pushExpected(input int x_sh, input int x_eo, input bit x_zero);
    exp_t ex;
    ex.sh   = sh_t'(x_sh);
    ex.eo   = eo_t'(x_eo);
    ex.zero = x_zero;
    sb.push_back(ex);
    n_acc++;
  endtask

  // Two result slots: room exists if either is free or one leaves this edge.
  task automatic checkInReady();
    checkOutput("in_ready", int'(bus.in_ready),
                (bus.out_ready || (n_acc - n_emit) < 2) ? 1 : 0);
  endtask

  task automatic applyStimulus(input vec_t v);
    int waited = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.fr       = v.fr;
    bus.er       = sh_t'(v.er);
    #1;
    checkInReady();
    while (!bus.in_ready && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
      checkInReady();
    end
    if (bus.in_ready) begin
      pushExpected(v.sh, v.eo, v.zero);
    end else begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 for 20 cycles, required acceptance");
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checkOutput("drain_empty", sb.size(), 0);
  endtask

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rdy_toggle) begin
        bus.out_ready = rdy_pat[rdy_idx % 8];
        rdy_idx++;
      end else begin
        bus.out_ready = rdy_force;
      end
    end
  end

  // Samples at negedge+2 so the stimulus side has already counted this
  // cycle's acceptance state against the previous emissions.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output: got sh=%0d eo=%0d with nothing outstanding, required no output",
                   bus.sh, bus.eo);
        end else begin
          mon_e = sb.pop_front();
          checkOutput($sformatf("sh[%0d]", n_emit), int'(bus.sh), int'(mon_e.sh));
          checkOutput($sformatf("eo[%0d]", n_emit), int'(bus.eo), int'(mon_e.eo));
          checkOutput($sformatf("zero[%0d]", n_emit), int'(bus.zero), int'(mon_e.zero));
        end
        n_emit++;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no completion, required finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.fr       = '0;
    bus.er       = '0;
    rst_n        = 1'b1;
    #1 rst_n     = 1'b0;

    @(negedge clk);
    #1;
    checkOutput("reset_out_valid", int'(bus.out_valid), 0);
    checkOutput("reset_sh", int'(bus.sh), 0);
    checkOutput("reset_eo", int'(bus.eo), 0);
    checkOutput("reset_zero", int'(bus.zero), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("reset_in_ready", int'(bus.in_ready), 1);

    // First vector alone: result visible two cycles after acceptance.
    applyStimulus(dir_v[0]);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    checkOutput("latency_cycle1_out_valid", int'(bus.out_valid), 0);
    @(negedge clk);
    #1;
    checkOutput("latency_cycle2_out_valid", int'(bus.out_valid), 1);

    for (int i = 1; i < 5; i++) begin
      applyStimulus(dir_v[i]);
    end
    idle();
    drain();

    // Back-to-back stream under the 1,0,0,0,1,1,0,1 out_ready pattern.
    #3;
    rdy_idx    = 0;
    rdy_toggle = 1'b1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(str_v[i]);
    end
    idle();
    drain();
    #3;
    rdy_toggle = 1'b0;
    rdy_force  = 1'b0;

    // Fill both stages with out_ready low, then reset with them full.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.fr       = 64'h0000_0000_0000_0001;
    bus.er       = sh_t'(0);
    #1;
    checkOutput("stall_in_ready_c1", int'(bus.in_ready), 1);
    pushExpected(63, -63, 1'b0);
    @(negedge clk);
    bus.fr = 64'h8000_0000_0000_0000;
    bus.er = sh_t'(5);
    #1;
    checkOutput("stall_in_ready_c2", int'(bus.in_ready), 1);
    pushExpected(0, 5, 1'b0);
    @(negedge clk);
    bus.fr = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.er = sh_t'(1);
    #1;
    checkOutput("stall_in_ready_c3", int'(bus.in_ready), 0);
    checkOutput("stall_out_valid", int'(bus.out_valid), 1);
    checkOutput("stall_held_sh", int'(bus.sh), 63);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_out_valid", int'(bus.out_valid), 0);
    checkOutput("async_reset_sh", int'(bus.sh), 0);
    sb.delete();
    n_acc        = 0;
    n_emit       = 0;
    bus.in_valid = 1'b0;
    rdy_force    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checkOutput("no_stale_output", int'(bus.out_valid), 0);
    end

    // The block must resume normally after the reset.
    applyStimulus(dir_v[2]);
    idle();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
